fwd_scoreboard: RTL and testbench



---
 rtl/fwd_scoreboard.sv | 129 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - shadow pipeline of destination tags driving bypass selects and load-use stall
// Optional stall-cycle counter enabled by defining FWD_PERF_CNT_EN.
module fwd_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int STAGES     = 3,
   parameter int LOAD_AVAIL = 3,
   parameter int SEL_W      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  use_rs1,
   input  logic                  use_rs2,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  rd_we,
   input  logic                  is_load,
   input  logic                  hold,
   input  logic                  flush,
   output logic [SEL_W-1:0]      sel_a,
   output logic [SEL_W-1:0]      sel_b,
   output logic                  stall,
   output logic [31:0]           stall_cnt
);

   // Keeps the flush copy index legal when only one stage is tracked.
   localparam int PREV = (STAGES > 1) ? STAGES - 1 : 1;

   logic [STAGES:1]         v_q, v_d;
   logic [STAGES:1]         we_q, we_d;
   logic [STAGES:1]         ld_q, ld_d;
   logic [REG_ADDR_W-1:0]   rd_q [1:STAGES];
   logic [REG_ADDR_W-1:0]   rd_d [1:STAGES];

   logic                    haz_a;
   logic                    haz_b;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
         if (issue_valid && use_rs1 && (rs1 != '0) &&
             v_q[k] && we_q[k] && (rd_q[k] == rs1)) begin
            sel_a = SEL_W'(k);
            haz_a = ld_q[k] && (k < LOAD_AVAIL);
         end
         if (issue_valid && use_rs2 && (rs2 != '0) &&
             v_q[k] && we_q[k] && (rd_q[k] == rs2)) begin
            sel_b = SEL_W'(k);
            haz_b = ld_q[k] && (k < LOAD_AVAIL);
         end
      end
      stall = haz_a | haz_b;
   end

   always_comb begin
      v_d  = v_q;
      we_d = we_q;
      ld_d = ld_q;
      rd_d = rd_q;
      if (hold) begin
         v_d = v_q;
      end else if (flush) begin
         // Everything younger than the oldest slot is squashed; that slot still advances.
         v_d = '0;
         if (STAGES > 1) begin
            v_d[STAGES]  = v_q[PREV];
            we_d[STAGES] = we_q[PREV];
            ld_d[STAGES] = ld_q[PREV];
            rd_d[STAGES] = rd_q[PREV];
         end
      end else begin
         for (int k = STAGES; k >= 2; k--) begin
            v_d[k]  = v_q[k-1];
            we_d[k] = we_q[k-1];
            ld_d[k] = ld_q[k-1];
            rd_d[k] = rd_q[k-1];
         end
         v_d[1]  = issue_valid & ~stall;
         we_d[1] = rd_we;
         ld_d[1] = is_load;
         rd_d[1] = rd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q  <= '0;
         we_q <= '0;
         ld_q <= '0;
         for (int k = 1; k <= STAGES; k++) begin
            rd_q[k] <= '0;
         end
      end else begin
         v_q  <= v_d;
         we_q <= we_d;
         ld_q <= ld_d;
         rd_q <= rd_d;
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed plus randomized bench for fwd_scoreboard against a tag-list model
module tb_fwd_scoreboard;

`ifdef FWD_PERF_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       issue_valid;
   logic [4:0] rs1, rs2, rd;
   logic       use_rs1, use_rs2, rd_we, is_load, hold, flush;
   logic [1:0] sel_a, sel_b;
   logic       stall;
   logic [31:0] stall_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit       v;
      bit       we;
      bit       ld;
      bit [4:0] rd;
   } tag_t;

   tag_t        pipe [1:3];
   int unsigned exp_cnt;

   fwd_scoreboard dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid),
      .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
      .rd(rd), .rd_we(rd_we), .is_load(is_load), .hold(hold), .flush(flush),
      .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_sel(input bit [4:0] rs, input bit use_r, output int sel, output bit haz);
      sel = 0;
      haz = 1'b0;
      if (!(issue_valid && use_r) || rs == 5'd0) return;
      for (int k = 1; k <= 3; k++) begin
         if (pipe[k].v && pipe[k].we && pipe[k].rd == rs) begin
            sel = k;
            haz = pipe[k].ld && (k < 3);
            return;
         end
      end
   endfunction

   bit exp_stall;

   task automatic settle();
      int  sa, sb;
      bit  ha, hb;
      @(negedge clk);
      model_sel(rs1, use_rs1, sa, ha);
      model_sel(rs2, use_rs2, sb, hb);
      exp_stall = ha | hb;
      check_val("sel_a", 32'(sel_a), 32'(sa));
      check_val("sel_b", 32'(sel_b), 32'(sb));
      check_val("stall", 32'(stall), 32'(exp_stall));
      check_val("stall_cnt", stall_cnt, CNT_EN ? exp_cnt : 32'd0);
   endtask

   task automatic advance();
      tag_t nxt [1:3];
      @(posedge clk);
      nxt = pipe;
      if (reset) begin
         for (int k = 1; k <= 3; k++) nxt[k] = '{1'b0, 1'b0, 1'b0, 5'd0};
         exp_cnt = 0;
      end else if (!hold) begin
         if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
         if (flush) begin
            nxt[3] = pipe[2];
            nxt[2].v = 1'b0;
            nxt[1].v = 1'b0;
         end else begin
            nxt[3] = pipe[2];
            nxt[2] = pipe[1];
            nxt[1] = '{issue_valid & ~exp_stall, rd_we, is_load, rd};
         end
      end
      pipe = nxt;
      #1;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   task automatic set_in(input bit iv, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                         input bit u2, input bit [4:0] d, input bit we, input bit ld);
      issue_valid = iv; rs1 = r1; use_rs1 = u1; rs2 = r2; use_rs2 = u2;
      rd = d; rd_we = we; is_load = ld; hold = 1'b0; flush = 1'b0; reset = 1'b0;
   endtask

   task automatic idle(input int n);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      exp_cnt = 0;
      exp_stall = 1'b0;
      for (int k = 1; k <= 3; k++) pipe[k] = '{1'b0, 1'b0, 1'b0, 5'd0};
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      advance();
      advance();
      reset = 1'b0;

      settle();
      check_val("rst_sel_a", 32'(sel_a), 32'd0);
      check_val("rst_stall", 32'(stall), 32'd0);
      check_val("rst_cnt", stall_cnt, 32'd0);
      advance();

      // back-to-back ALU
      set_in(1, 0, 0, 0, 0, 5, 1, 0); tick();
      set_in(1, 5, 1, 0, 0, 0, 0, 0); settle();
      check_val("b2b_sel1", 32'(sel_a), 32'd1);
      check_val("b2b_stall", 32'(stall), 32'd0);
      advance();
      set_in(1, 5, 1, 0, 0, 0, 0, 0); settle();
      check_val("b2b_sel2", 32'(sel_a), 32'd2);
      advance();
      idle(3);

      // load-use
      set_in(1, 0, 0, 0, 0, 7, 1, 1); tick();
      set_in(1, 0, 0, 7, 1, 0, 0, 0); settle();
      check_val("lu_stall1", 32'(stall), 32'd1);
      advance();
      settle();
      check_val("lu_stall2", 32'(stall), 32'd1);
      advance();
      settle();
      check_val("lu_sel_b", 32'(sel_b), 32'd3);
      check_val("lu_stall3", 32'(stall), 32'd0);
      check_val("lu_cnt", stall_cnt, CNT_EN ? 32'd2 : 32'd0);
      advance();
      idle(3);

      // youngest wins, x0 never matches
      set_in(1, 0, 0, 0, 0, 3, 1, 0); tick();
      set_in(1, 0, 0, 0, 0, 3, 1, 0); tick();
      set_in(1, 3, 1, 3, 1, 0, 0, 0); settle();
      check_val("young_a", 32'(sel_a), 32'd1);
      check_val("young_b", 32'(sel_b), 32'd1);
      advance();
      set_in(1, 0, 0, 0, 0, 0, 1, 0); tick();
      set_in(1, 0, 1, 0, 0, 0, 0, 0); settle();
      check_val("x0_sel", 32'(sel_a), 32'd0);
      advance();
      idle(3);

      // flush keeps only the entry moving into the last stage
      set_in(1, 0, 0, 0, 0, 6, 1, 0); tick();
      set_in(1, 0, 0, 0, 0, 9, 1, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); flush = 1'b1; tick();
      set_in(1, 9, 1, 6, 1, 0, 0, 0); settle();
      check_val("flush_x9", 32'(sel_a), 32'd0);
      check_val("flush_x6", 32'(sel_b), 32'd3);
      advance();
      idle(3);

      // hold freezes the tag at stage 1
      set_in(1, 0, 0, 0, 0, 4, 1, 0); tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 4, 1, 0, 0, 0, 0, 0); hold = 1'b1; settle();
         check_val("hold_sel", 32'(sel_a), 32'd1);
         advance();
      end
      set_in(1, 4, 1, 0, 0, 0, 0, 0); tick();
      settle();
      check_val("unhold_sel", 32'(sel_a), 32'd2);
      advance();

      // reset mid-stream
      set_in(1, 0, 0, 0, 0, 1, 1, 1); tick();
      set_in(1, 0, 0, 0, 0, 2, 1, 0); tick();
      set_in(1, 0, 0, 0, 0, 3, 1, 0); tick();
      set_in(1, 1, 1, 2, 1, 0, 0, 0); reset = 1'b1; tick();
      set_in(1, 1, 1, 2, 1, 0, 0, 0); settle();
      check_val("mrst_sel_a", 32'(sel_a), 32'd0);
      check_val("mrst_sel_b", 32'(sel_b), 32'd0);
      check_val("mrst_stall", 32'(stall), 32'd0);
      check_val("mrst_cnt", stall_cnt, 32'd0);
      advance();

      for (int i = 0; i < 3000; i++) begin
         issue_valid = 1'($urandom_range(0, 3) != 0);
         rs1     = 5'($urandom_range(0, 7));
         rs2     = 5'($urandom_range(0, 7));
         use_rs1 = 1'($urandom_range(0, 1));
         use_rs2 = 1'($urandom_range(0, 1));
         rd      = 5'($urandom_range(0, 7));
         rd_we   = 1'($urandom_range(0, 3) != 0);
         is_load = 1'($urandom_range(0, 2) == 0);
         hold    = 1'($urandom_range(0, 7) == 0);
         flush   = 1'($urandom_range(0, 7) == 0);
         reset   = 1'($urandom_range(0, 63) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
